axi_burst_read_responder: RTL and testbench

// AXI4 read-channel responder (slave) backed by a 64-bit word memory array. It serves the
// AR/R bursts issued by the cache line-fill logic (8-beat WRAP, 8-byte beats).

---
 rtl/axi_burst_read_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_burst_read_responder.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_read_responder.sv
// AXI4 read-channel responder backed by a word-addressed memory array.
// Serves one FIXED/INCR/WRAP burst at a time with a programmable first-beat latency.
module axi_burst_read_responder #(
    parameter int unsigned             addr_width   = 64,
    parameter int unsigned             data_width   = 64,
    parameter int unsigned             mem_words    = 1024,
    parameter logic [addr_width-1:0]   base_addr    = '0,
    parameter int unsigned             read_latency = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    input  logic [addr_width-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [data_width-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    input  logic                         mem_we,
    input  logic [$clog2(mem_words)-1:0] mem_waddr,
    input  logic [data_width-1:0]        mem_wdata
);

    localparam int unsigned IDX_W = $clog2(mem_words);
    localparam int unsigned LAT_W = (read_latency > 1) ? $clog2(read_latency) : 1;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATENCY,
        S_BEAT
    } state_t;

    state_t                  state_q, state_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [data_width-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;
    logic [addr_width-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [1:0]              err_q, err_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;

    logic [data_width-1:0]   mem_q [mem_words];

    logic                    load;
    logic [addr_width-1:0]   ld_addr;
    logic [7:0]              ld_cnt;
    logic [1:0]              ld_err;
    logic [addr_width-1:0]   ld_off;
    logic                    ld_oor;
    logic [IDX_W-1:0]        ld_idx;

    function automatic logic [addr_width-1:0] step_of(input logic [2:0] size);
        return addr_width'(1) << size;
    endfunction

    // Burst-wide error: DECERR outranks the WRAP legality checks.
    function automatic logic [1:0] burst_err(input logic [1:0]            burst,
                                             input logic [2:0]            size,
                                             input logic [7:0]            len,
                                             input logic [addr_width-1:0] addr);
        logic [1:0] err;
        err = RESP_OKAY;
        if (burst == BURST_RSVD || size > 3'd3) begin
            err = RESP_DECERR;
        end else if (burst == BURST_WRAP &&
                     (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                      (addr & (step_of(size) - addr_width'(1))) != '0)) begin
            err = RESP_SLVERR;
        end
        return err;
    endfunction

    function automatic logic [addr_width-1:0] next_addr(input logic [addr_width-1:0] addr,
                                                        input logic [1:0]            burst,
                                                        input logic [2:0]            size,
                                                        input logic [7:0]            len);
        logic [addr_width-1:0] step;
        logic [addr_width-1:0] mask;
        logic [addr_width-1:0] nxt;
        step = step_of(size);
        mask = ((addr_width'(len) + addr_width'(1)) << size) - addr_width'(1);
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_WRAP:  nxt = (addr & ~mask) | ((addr + step) & mask);
            default:     nxt = addr + step;
        endcase
        return nxt;
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        err_d      = err_q;
        beat_cnt_d = beat_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        arready_d  = 1'b0;
        load       = 1'b0;
        ld_addr    = addr_q;
        ld_cnt     = beat_cnt_q;
        ld_err     = err_q;

        case (state_q)
            S_IDLE: begin
                arready_d = 1'b1;
                if (arready_q && s_axi_arvalid) begin
                    arready_d  = 1'b0;
                    addr_d     = s_axi_araddr;
                    len_d      = s_axi_arlen;
                    size_d     = s_axi_arsize;
                    burst_d    = s_axi_arburst;
                    err_d      = burst_err(s_axi_arburst, s_axi_arsize, s_axi_arlen, s_axi_araddr);
                    beat_cnt_d = '0;
                    if (read_latency == 1) begin
                        load    = 1'b1;
                        ld_addr = s_axi_araddr;
                        ld_cnt  = '0;
                        ld_err  = err_d;
                        state_d = S_BEAT;
                    end else begin
                        lat_cnt_d = LAT_W'(read_latency - 1);
                        state_d   = S_LATENCY;
                    end
                end
            end
            S_LATENCY: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q <= LAT_W'(1)) begin
                    lat_cnt_d = '0;
                    load      = 1'b1;
                    state_d   = S_BEAT;
                end
            end
            S_BEAT: begin
                if (rvalid_q && s_axi_rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        addr_d     = next_addr(addr_q, burst_q, size_q, len_q);
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        load       = 1'b1;
                        ld_addr    = addr_d;
                        ld_cnt     = beat_cnt_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        ld_off = ld_addr - base_addr;
        ld_oor = (ld_addr < base_addr) || ((ld_off >> 3) >= addr_width'(mem_words));
        ld_idx = ld_off[IDX_W+2:3];

        if (load) begin
            rvalid_d = 1'b1;
            rlast_d  = (ld_cnt == len_d);
            if (ld_err != RESP_OKAY) begin
                rresp_d = ld_err;
                rdata_d = '0;
            end else if (ld_oor) begin
                rresp_d = RESP_SLVERR;
                rdata_d = '0;
            end else begin
                rresp_d = RESP_OKAY;
                rdata_d = mem_q[ld_idx];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            err_q      <= RESP_OKAY;
            beat_cnt_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            err_q      <= err_d;
            beat_cnt_q <= beat_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    // NOTE: the backing array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_burst_read_responder.sv
// Scoreboard bench for axi_burst_read_responder: expected beats are queued when an AR is
// issued and compared against the beats collected from the R channel.
module tb_axi_burst_read_responder;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    localparam logic [1:0] FIXED = 2'd0;
    localparam logic [1:0] INCR  = 2'd1;
    localparam logic [1:0] WRAP  = 2'd2;
    localparam logic [1:0] RSVD  = 2'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        mem_we = 1'b0;
    logic [9:0]  mem_waddr = '0;
    logic [63:0] mem_wdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hold_viol = 0;
    int first_rv_cyc = -1;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    rlast_cyc_q[$];

    axi_burst_read_responder dut (
        .clock         (clock),
        .reset         (reset),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_arsize  (arsize),
        .s_axi_arburst (arburst),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic push_exp(input logic [63:0] d, input logic [1:0] r, input logic l);
        beat_t b;
        b.data = d;
        b.resp = r;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Holds arvalid until accepted; returns the cycle in which arvalid&&arready were both high.
    task automatic issue_ar(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input bit keep, output int hs_cyc);
        int k = 0;
        hs_cyc  = -1;
        arvalid = 1'b1;
        araddr  = a;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        while (k < 200) begin
            @(negedge clock);
            if (arready) begin
                hs_cyc = cyc;
                break;
            end
            @(posedge clock);
            #1;
            k++;
        end
        if (hs_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout addr=%h: arready never seen within 200 cycles", a);
        end else begin
            @(posedge clock);
            #1;
        end
        if (!keep) arvalid = 1'b0;
    endtask

    // Collects n beats into obs_q; toggle drives rready 1,0,1,0,... per cycle.
    task automatic collect(input int n, input bit toggle, input int budget);
        int    got = 0;
        int    k = 0;
        bit    prev_stall = 1'b0;
        beat_t prev;
        beat_t cur;
        prev = '0;
        first_rv_cyc = -1;
        while (got < n && k < budget) begin
            rready = toggle ? (k % 2 == 0) : 1'b1;
            @(negedge clock);
            cur.data = rdata;
            cur.resp = rresp;
            cur.last = rlast;
            if (rvalid) begin
                if (first_rv_cyc < 0) first_rv_cyc = cyc;
                if (prev_stall && cur !== prev) hold_viol++;
                if (rready) begin
                    obs_q.push_back(cur);
                    got++;
                    if (rlast) rlast_cyc_q.push_back(cyc);
                end
                prev_stall = !rready;
                prev = cur;
            end else begin
                prev_stall = 1'b0;
            end
            @(posedge clock);
            #1;
            k++;
        end
        rready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({arready, rvalid, rlast, rresp} !== 5'b0 || rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: arready=%b rvalid=%b rlast=%b rresp=%b rdata=%h, want all zero",
                     arready, rvalid, rlast, rresp, rdata);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_arready_early: arready=%b want 0 before first edge", arready);
        end
        @(negedge clock);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_arready_rise: arready=%b want 1 one cycle after release", arready);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            #1;
            mem_we    = 1'b1;
            mem_waddr = 10'(i);
            mem_wdata = 64'h1000 + 64'(i);
        end
        @(posedge clock);
        #1;
        mem_waddr = 10'd1023;
        mem_wdata = 64'hABCD;
        @(posedge clock);
        #1;
        mem_we = 1'b0;
    endtask

    task automatic test_wrap();
        int    hs;
        beat_t e;
        beat_t o;
        for (int i = 0; i < 8; i++) push_exp(64'h1000 + 64'((i + 4) % 8), 2'b00, i == 7);
        issue_ar(64'h20, 8'd7, 3'd3, WRAP, 1'b0, hs);
        collect(8, 1'b0, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL wrap_missing: no beat observed, want %h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL wrap_beat: got data=%h resp=%b last=%b want data=%h resp=%b last=%b",
                             o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int    hs;
        beat_t e;
        beat_t o;
        hold_viol = 0;
        for (int i = 0; i < 4; i++) push_exp(64'h1000 + 64'(i), 2'b00, i == 3);
        issue_ar(64'h0, 8'd3, 3'd3, INCR, 1'b0, hs);
        collect(4, 1'b1, 100);
        @(negedge clock);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_extra_beat: rvalid=%b after last beat, want 0", rvalid);
        end
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d stalled beats changed, want 0", hold_viol);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL bp_missing: no beat observed, want %h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL bp_beat: got data=%h resp=%b last=%b want data=%h resp=%b last=%b",
                             o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_timing();
        int    t;
        int    ar_cyc = -1;
        beat_t e;
        beat_t o;
        rready = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(64'h1000 + 64'(i), 2'b00, i == 7);
        rlast_cyc_q.delete();
        issue_ar(64'h0, 8'd7, 3'd3, INCR, 1'b0, t);
        collect(8, 1'b0, 100);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (arready) begin
                ar_cyc = cyc;
                break;
            end
        end
        checks++;
        if (first_rv_cyc != t + 4) begin
            errors++;
            $display("FAIL timing_first_rvalid: cycle %0d want %0d", first_rv_cyc, t + 4);
        end
        checks++;
        if (rlast_cyc_q.size() != 1 || rlast_cyc_q[0] != t + 11) begin
            errors++;
            $display("FAIL timing_rlast: %0d rlast beats, want one at cycle %0d", rlast_cyc_q.size(), t + 11);
        end
        checks++;
        if (ar_cyc != t + 13) begin
            errors++;
            $display("FAIL timing_arready: cycle %0d want %0d", ar_cyc, t + 13);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL timing_missing: no beat observed, want %h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL timing_beat: got data=%h resp=%b last=%b want data=%h resp=%b last=%b",
                             o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_errors();
        int    hs;
        beat_t e;
        beat_t o;
        push_exp(64'h0, 2'b10, 1'b0);
        push_exp(64'h0, 2'b10, 1'b1);
        issue_ar(64'd8192, 8'd1, 3'd3, INCR, 1'b0, hs);
        collect(2, 1'b0, 100);
        push_exp(64'hABCD, 2'b00, 1'b0);
        push_exp(64'h0, 2'b10, 1'b1);
        issue_ar(64'h1FF8, 8'd1, 3'd3, INCR, 1'b0, hs);
        collect(2, 1'b0, 100);
        for (int i = 0; i < 3; i++) push_exp(64'h0, 2'b11, i == 2);
        issue_ar(64'h0, 8'd2, 3'd3, RSVD, 1'b0, hs);
        collect(3, 1'b0, 100);
        for (int i = 0; i < 3; i++) push_exp(64'h0, 2'b10, i == 2);
        issue_ar(64'h0, 8'd2, 3'd3, WRAP, 1'b0, hs);
        collect(3, 1'b0, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL err_missing: no beat observed, want resp=%b", e.resp);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL err_beat: got data=%h resp=%b last=%b want data=%h resp=%b last=%b",
                             o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int    hs;
        beat_t e;
        beat_t o;
        for (int i = 0; i < 3; i++) push_exp(64'h1000 + 64'(i), 2'b00, 1'b0);
        issue_ar(64'h0, 8'd7, 3'd3, INCR, 1'b0, hs);
        collect(3, 1'b0, 100);
        reset = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: rvalid=%b arready=%b want 0 0", rvalid, arready);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        push_exp(64'h1003, 2'b00, 1'b1);
        issue_ar(64'h18, 8'd0, 3'd3, INCR, 1'b0, hs);
        collect(1, 1'b0, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL midreset_missing: no beat observed, want %h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL midreset_beat: got data=%h resp=%b last=%b want data=%h resp=%b last=%b",
                             o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int    hs1;
        int    hs2;
        beat_t e;
        beat_t o;
        rlast_cyc_q.delete();
        push_exp(64'h1002, 2'b00, 1'b0);
        push_exp(64'h1003, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) push_exp(64'h1001, 2'b00, i == 2);
        fork
            begin
                issue_ar(64'h10, 8'd1, 3'd3, INCR, 1'b1, hs1);
                issue_ar(64'h8, 8'd2, 3'd3, FIXED, 1'b0, hs2);
            end
            collect(5, 1'b0, 200);
        join
        checks++;
        if (rlast_cyc_q.size() != 2 || hs2 != rlast_cyc_q[0] + 2) begin
            errors++;
            $display("FAIL b2b_accept: second AR at cycle %0d, first rlast at %0d (%0d rlast beats), want rlast+2",
                     hs2, (rlast_cyc_q.size() > 0) ? rlast_cyc_q[0] : -1, rlast_cyc_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL b2b_missing: no beat observed, want %h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b_beat: got data=%h resp=%b last=%b want data=%h resp=%b last=%b",
                             o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_wrap();
        test_backpressure();
        test_timing();
        test_errors();
        test_reset_mid_burst();
        test_back_to_back();
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_beats: %0d unexpected beats, want 0", obs_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
